bidir_shift_reg: RTL and testbench

- Parameterised-width bidirectional shift register with a serial input and a parallel output.
- Each enabled clock edge shifts the register left or right by one position.
- In linear mode the serial input feeds the vacated end; in circular mode the bit that falls off one end wraps into the other.
- Used as a generic serial-to-parallel or rotate element in datapath and control logic.

---
 rtl/bidir_shift_reg.sv | 72 +++++++
 tb/tb_bidir_shift_reg.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bidir_shift_reg.sv
// -----------------------------------------------------------------------------
// bidir_shift_reg
//
// Parameterised-width bidirectional shift register with a serial input and a
// parallel output. Each enabled rising clock edge moves the contents one
// position left (toward the top bit) or right (toward bit 0). In linear mode
// the serial input d fills the vacated end. In circular mode the bit shifted
// out of one end wraps into the other end, and d is ignored.
//
// Parameters
//   MSB       register width in bits (legal range MSB >= 2)
//
// Ports
//   clk       clock; all state changes happen on the rising edge
//   rstn      asynchronous active-low reset; clears the register at once
//   d         serial data in (used only when circular = 0)
//   en        shift enable: 1 = shift on this edge, 0 = hold
//   dir       direction: 0 = shift left (toward MSB), 1 = shift right
//   circular  mode: 0 = linear shift with d inserted, 1 = rotate
//   out       parallel register contents, driven straight from the flops
//
// There is no handshake in this block: every input is sampled on every rising
// edge, and en is a plain qualifier rather than a valid/ready pair.
// -----------------------------------------------------------------------------
module bidir_shift_reg #(
  parameter int MSB = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           d,
  input  logic           en,
  input  logic           dir,
  input  logic           circular,
  output logic [MSB-1:0] out
);

  logic [MSB-1:0] shift_q;
  logic [MSB-1:0] shift_d;
  logic           left_fill;
  logic           right_fill;

  // The bit that enters the vacated end. In circular mode it is the bit
  // leaving the opposite end, so no information is lost.
  always_comb begin
    left_fill  = circular ? shift_q[MSB-1] : d;
    right_fill = circular ? shift_q[0]     : d;
  end

  always_comb begin
    shift_d = shift_q;
    if (en) begin
      if (dir) begin
        shift_d = {right_fill, shift_q[MSB-1:1]};
      end else begin
        shift_d = {shift_q[MSB-2:0], left_fill};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  // Output comes directly from the state flops; there is no combinational
  // path from any input to out.
  assign out = shift_q;

endmodule

// File: tb/tb_bidir_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_bidir_shift_reg
//
// Bench for bidir_shift_reg (MSB = 8). The reference model holds the register
// as an unsigned integer and applies each operation with multiply/divide/
// modulo arithmetic. Expected values go through an expected queue and are
// compared on the falling edge after each rising edge.
// -----------------------------------------------------------------------------
module tb_bidir_shift_reg;

  localparam int W = 8;
  localparam int MOD = 1 << W;
  localparam int TOP = 1 << (W - 1);

  logic         clk;
  logic         rstn;
  logic         d;
  logic         en;
  logic         dir;
  logic         circular;
  logic [W-1:0] out;

  int unsigned  model;
  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_fail;

  bidir_shift_reg #(.MSB(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .d        (d),
    .en       (en),
    .dir      (dir),
    .circular (circular),
    .out      (out)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  function automatic int unsigned model_next(input int unsigned m,
                                             input logic e, input logic dr,
                                             input logic c, input logic dd);
    int unsigned fill;
    if (!e) return m;
    if (!dr) begin
      fill = c ? (m / TOP) : int'(dd);
      return (m * 2 + fill) % MOD;
    end else begin
      fill = c ? (m % 2) : int'(dd);
      return m / 2 + fill * TOP;
    end
  endfunction

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%b expected=%b at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Apply one set of inputs, let one rising edge pass, then compare on the
  // following falling edge against the model's prediction.
  task automatic step(input string tag, input logic e, input logic dr,
                      input logic c, input logic dd);
    en = e; dir = dr; circular = c; d = dd;
    @(posedge clk);
    if (rstn) model = model_next(model, e, dr, c, dd);
    exp_q.push_back(model[W-1:0]);
    @(negedge clk);
    check(tag, out, exp_q.pop_front());
  endtask

  // Asynchronous reset pulse placed between clock edges (called at negedge).
  task automatic async_reset_pulse(input string tag);
    #2 rstn = 1'b0;
    #1 check(tag, out, '0);
    model = 0;
    #1 rstn = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [W-1:0] pattern;
    int           pc;

    n_checks = 0; n_fail = 0; model = 0;
    rstn = 1'b0; en = 1'b0; dir = 1'b0; circular = 1'b0; d = 1'b0;

    // Reset state held across edges.
    @(negedge clk);
    check("reset_init", out, '0);
    step("reset_hold", 1'b1, 1'b0, 1'b0, 1'b1);
    rstn = 1'b1;

    // Linear left, linear right, rotate left, rotate right.
    step("lin_left_d1", 1'b1, 1'b0, 1'b0, 1'b1);  check("lin_left_d1_c", out, 8'b00000001);
    step("lin_left_d0", 1'b1, 1'b0, 1'b0, 1'b0);  check("lin_left_d0_c", out, 8'b00000010);
    step("lin_right_d1", 1'b1, 1'b1, 1'b0, 1'b1); check("lin_right_d1_c", out, 8'b10000001);
    step("lin_right_d0", 1'b1, 1'b1, 1'b0, 1'b0); check("lin_right_d0_c", out, 8'b01000000);
    step("rot_left_d1", 1'b1, 1'b0, 1'b1, 1'b1);  check("rot_left_d1_c", out, 8'b10000000);
    step("rot_left_d0", 1'b1, 1'b0, 1'b1, 1'b0);  check("rot_left_d0_c", out, 8'b00000001);
    step("rot_right_d1", 1'b1, 1'b1, 1'b1, 1'b1); check("rot_right_d1_c", out, 8'b10000000);
    step("rot_right_d0", 1'b1, 1'b1, 1'b1, 1'b0); check("rot_right_d0_c", out, 8'b01000000);

    // Load 10110011 by linear left shifting, MSB first.
    pattern = 8'b10110011;
    for (int i = W - 1; i >= 0; i--) step("load", 1'b1, 1'b0, 1'b0, pattern[i]);
    check("load_c", out, pattern);

    // Full rotation in each direction restores the value; popcount preserved.
    for (int i = 0; i < W; i++) begin
      step("rot8_left", 1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      pc = $countones(out);
      check("rot_left_popcount", W'(pc), W'(5));
    end
    check("rot8_left_restore", out, pattern);
    for (int i = 0; i < W; i++) begin
      step("rot8_right", 1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
      pc = $countones(out);
      check("rot_right_popcount", W'(pc), W'(5));
    end
    check("rot8_right_restore", out, pattern);

    // Hold with en=0 while the other controls toggle.
    for (int i = 0; i < 5; i++)
      step("hold", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    check("hold_c", out, pattern);

    // Asynchronous reset mid-cycle with out = 10110011, then held across edges.
    #2 rstn = 1'b0;
    #1 check("async_reset", out, '0);
    model = 0;
    @(negedge clk);
    step("reset_low_edge1", 1'b1, 1'b0, 1'b0, 1'b1);
    step("reset_low_edge2", 1'b1, 1'b1, 1'b1, 1'b1);
    rstn = 1'b1;

    // Linear fill: eight ones then one zero.
    for (int i = 0; i < W; i++) step("fill_ones", 1'b1, 1'b0, 1'b0, 1'b1);
    check("fill_ones_c", out, 8'b11111111);
    step("fill_zero", 1'b1, 1'b0, 1'b0, 1'b0);
    check("fill_zero_c", out, 8'b11111110);

    // Randomized operation with occasional asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) async_reset_pulse("rand_async_reset");
      step("random", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the stimulus is purely clock-driven, but never let it hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
